// File: rtl/orca_pkg.sv
// rtl/orca_pkg.sv - shared flit type and edge endpoint FSM state encodings
//
// Purpose: common definitions for the mesh edge endpoint.
//   FLIT_W          default flit width in bits
//   flit_t          one flit at the default width
//   edge_tx_state_t injector FSM states
//   edge_rx_state_t receive parser states
package orca_pkg;

  localparam int FLIT_W = 16;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HEAD,
    TX_SIZE,
    TX_PAY
  } edge_tx_state_t;

  typedef enum logic [1:0] {
    RX_HDR,
    RX_SIZE,
    RX_PAY
  } edge_rx_state_t;

endpackage

// File: rtl/edge_fifo.sv
// rtl/edge_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose: buffers WIDTH-bit words; the head word is visible on dout
// whenever empty is low, with no read latency.
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-low reset
//   push, din       write din when push and not full
//   pop             drop the head word when pop and not empty
//   dout            head word (undefined when empty)
//   full, empty     occupancy flags, derived from the registered count
//   count           number of stored words, 0..DEPTH
module edge_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
      else if (!do_push && do_pop) cnt <= cnt - (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is visible until a word is pushed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/noc_edge_endpoint.sv
// rtl/noc_edge_endpoint.sv - mesh boundary traffic sink and synthetic packet injector
//
// Purpose: receives packets leaving the mesh over a credit link, marks the
// last flit of each packet and buffers {last, flit} for a stream consumer;
// injects packets (dest, size, counting payload) into the mesh on request.
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-low reset
//   rx_i, data_i, credit_o        inbound credit link from the router
//   tx_o, data_o, credit_i        outbound credit link to the router
//   send_valid_i, send_ready_o    injection request handshake
//   send_dest_i/size_i/seed_i     header, payload length, first payload value
//   recv_valid_o/data_o/last_o    buffered flit stream (FIFO head)
//   recv_ready_i                  consumer pop
//   rx_pkt_cnt_o, tx_pkt_cnt_o    completed packet counters (wrap at 2^32)
module noc_edge_endpoint
  import orca_pkg::*;
#(
  parameter int FLIT_WIDTH = FLIT_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_i,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  output logic                  tx_o,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic                  credit_i,
  input  logic                  send_valid_i,
  output logic                  send_ready_o,
  input  logic [FLIT_WIDTH-1:0] send_dest_i,
  input  logic [FLIT_WIDTH-1:0] send_size_i,
  input  logic [FLIT_WIDTH-1:0] send_seed_i,
  output logic                  recv_valid_o,
  output logic [FLIT_WIDTH-1:0] recv_data_o,
  output logic                  recv_last_o,
  input  logic                  recv_ready_i,
  output logic [31:0]           rx_pkt_cnt_o,
  output logic [31:0]           tx_pkt_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  // Low during reset, high from the first edge after release; keeps credit
  // and send_ready low while reset is asserted.
  logic alive_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  // ---------------- RX path ----------------
  edge_rx_state_t        rx_state, rx_next;
  logic [FLIT_WIDTH-1:0] rx_size;
  logic [FLIT_WIDTH-1:0] rx_cnt;
  logic                  rx_push;
  logic                  rx_last;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [FLIT_WIDTH:0]   fifo_dout;

  // Credit depends only on registered state, never on rx_i.
  assign credit_o = alive_q & (fifo_count != CNT_FULL);
  assign rx_push  = rx_i & alive_q & ~fifo_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rx_state <= RX_HDR;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_HDR:  if (rx_push) rx_next = RX_SIZE;
      RX_SIZE: if (rx_push) rx_next = (data_i == '0) ? RX_HDR : RX_PAY;
      RX_PAY:  if (rx_push && rx_last) rx_next = RX_HDR;
      default: rx_next = RX_HDR;
    endcase
  end

  always_comb begin
    rx_last = 1'b0;
    case (rx_state)
      RX_SIZE: rx_last = (data_i == '0);
      RX_PAY:  rx_last = (rx_cnt == rx_size - FLIT_WIDTH'(1));
      default: rx_last = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_size      <= '0;
      rx_cnt       <= '0;
      rx_pkt_cnt_o <= '0;
    end else if (rx_push) begin
      if (rx_state == RX_SIZE) begin
        rx_size <= data_i;
        rx_cnt  <= '0;
      end else if (rx_state == RX_PAY) begin
        rx_cnt <= rx_cnt + FLIT_WIDTH'(1);
      end
      if (rx_last) rx_pkt_cnt_o <= rx_pkt_cnt_o + 32'd1;
    end
  end

  edge_fifo #(
    .WIDTH (FLIT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .pop   (recv_ready_i),
    .din   ({rx_last, data_i}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stale storage is masked so an empty FIFO always shows zeros.
  assign recv_valid_o = ~fifo_empty;
  assign recv_data_o  = fifo_empty ? '0 : fifo_dout[FLIT_WIDTH-1:0];
  assign recv_last_o  = ~fifo_empty & fifo_dout[FLIT_WIDTH];

  // ---------------- TX injector ----------------
  edge_tx_state_t        tx_state, tx_next;
  logic [FLIT_WIDTH-1:0] tx_dest;
  logic [FLIT_WIDTH-1:0] tx_size;
  logic [FLIT_WIDTH-1:0] tx_seed;
  logic [FLIT_WIDTH-1:0] tx_k;
  logic                  tx_accept;
  logic                  tx_done;

  assign tx_accept = send_valid_i & send_ready_o;
  assign tx_done   = credit_i &
                     (((tx_state == TX_SIZE) && (tx_size == '0)) ||
                      ((tx_state == TX_PAY) && (tx_k == tx_size - FLIT_WIDTH'(1))));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_accept) tx_next = TX_HEAD;
      TX_HEAD: if (credit_i) tx_next = TX_SIZE;
      TX_SIZE: if (credit_i) tx_next = (tx_size == '0) ? TX_IDLE : TX_PAY;
      TX_PAY:  if (tx_done) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_o         = 1'b0;
    data_o       = '0;
    send_ready_o = 1'b0;
    case (tx_state)
      TX_IDLE: send_ready_o = alive_q;
      TX_HEAD: begin tx_o = 1'b1; data_o = tx_dest; end
      TX_SIZE: begin tx_o = 1'b1; data_o = tx_size; end
      TX_PAY:  begin tx_o = 1'b1; data_o = tx_seed + tx_k; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_dest      <= '0;
      tx_size      <= '0;
      tx_seed      <= '0;
      tx_k         <= '0;
      tx_pkt_cnt_o <= '0;
    end else begin
      if (tx_accept) begin
        tx_dest <= send_dest_i;
        tx_size <= send_size_i;
        tx_seed <= send_seed_i;
        tx_k    <= '0;
      end else if (tx_state == TX_PAY && credit_i) begin
        tx_k <= tx_k + FLIT_WIDTH'(1);
      end
      if (tx_done) tx_pkt_cnt_o <= tx_pkt_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_noc_edge_endpoint.sv
// tb/tb_noc_edge_endpoint.sv - scoreboard bench for noc_edge_endpoint
module tb_noc_edge_endpoint;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        credit_o;
  logic        tx_o;
  logic [15:0] data_o;
  logic        credit_i = 1'b0;
  logic        send_valid_i = 1'b0;
  logic        send_ready_o;
  logic [15:0] send_dest_i = '0;
  logic [15:0] send_size_i = '0;
  logic [15:0] send_seed_i = '0;
  logic        recv_valid_o;
  logic [15:0] recv_data_o;
  logic        recv_last_o;
  logic        recv_ready_i = 1'b0;
  logic [31:0] rx_pkt_cnt_o;
  logic [31:0] tx_pkt_cnt_o;

  int checks = 0;
  int failures = 0;

  logic [15:0] tx_q[$];
  logic [16:0] rx_q[$];

  always #5 clock = ~clock;

  noc_edge_endpoint dut (
    .clock        (clock),
    .reset        (reset),
    .rx_i         (rx_i),
    .data_i       (data_i),
    .credit_o     (credit_o),
    .tx_o         (tx_o),
    .data_o       (data_o),
    .credit_i     (credit_i),
    .send_valid_i (send_valid_i),
    .send_ready_o (send_ready_o),
    .send_dest_i  (send_dest_i),
    .send_size_i  (send_size_i),
    .send_seed_i  (send_seed_i),
    .recv_valid_o (recv_valid_o),
    .recv_data_o  (recv_data_o),
    .recv_last_o  (recv_last_o),
    .recv_ready_i (recv_ready_i),
    .rx_pkt_cnt_o (rx_pkt_cnt_o),
    .tx_pkt_cnt_o (tx_pkt_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Outbound link monitor: a transfer happens at the next rising edge.
  always @(negedge clock) begin
    if (reset && tx_o && credit_i) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual=%h required=none", data_o);
      end else begin
        chk("tx_flit", 32'(data_o), 32'(tx_q.pop_front()));
      end
    end
  end

  // Receive stream monitor: {last, data} compared on each pop.
  always @(negedge clock) begin
    if (reset && recv_valid_o && recv_ready_i) begin
      if (rx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL recv_unexpected actual=%h required=none", {recv_last_o, recv_data_o});
      end else begin
        chk("recv_flit", 32'({recv_last_o, recv_data_o}), 32'(rx_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_tx(input logic [15:0] d);
    tx_q.push_back(d);
  endtask

  task automatic exp_rx(input logic last, input logic [15:0] d);
    rx_q.push_back({last, d});
  endtask

  task automatic send_pkt(input logic [15:0] d, input logic [15:0] s, input logic [15:0] sd);
    int n = 0;
    while (!send_ready_o && n < 100) begin tick(); n++; end
    chk("send_ready_wait", 32'(send_ready_o), 32'd1);
    send_valid_i = 1'b1;
    send_dest_i  = d;
    send_size_i  = s;
    send_seed_i  = sd;
    tick();
    send_valid_i = 1'b0;
    send_dest_i  = 16'hDEAD;
    send_size_i  = 16'hBEEF;
    send_seed_i  = 16'hCAFE;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (!send_ready_o && n < 200) begin tick(); n++; end
    chk("tx_idle_wait", 32'(send_ready_o), 32'd1);
  endtask

  task automatic rx_flit(input logic [15:0] d);
    int n = 0;
    while (!credit_o && n < 100) begin tick(); n++; end
    chk("rx_credit_wait", 32'(credit_o), 32'd1);
    rx_i   = 1'b1;
    data_i = d;
    tick();
    rx_i   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    recv_ready_i = 1'b1;
    while (rx_q.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain_queue_empty", 32'(rx_q.size()), 32'd0);
    chk("drain_recv_valid", 32'(recv_valid_o), 32'd0);
    recv_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (5) tick();
    chk("rst_credit", 32'(credit_o), 32'd0);
    chk("rst_tx", 32'(tx_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_send_ready", 32'(send_ready_o), 32'd0);
    chk("rst_recv_valid", 32'(recv_valid_o), 32'd0);
    chk("rst_rx_cnt", rx_pkt_cnt_o, 32'd0);
    chk("rst_tx_cnt", tx_pkt_cnt_o, 32'd0);
    reset = 1'b1;
    chk("rel_credit_before_edge", 32'(credit_o), 32'd0);
    tick();
    chk("rel_credit", 32'(credit_o), 32'd1);
    chk("rel_send_ready", 32'(send_ready_o), 32'd1);

    // Inject 0x0102 size 3 seed 0xFFFE: five back-to-back flits
    credit_i = 1'b1;
    exp_tx(16'h0102); exp_tx(16'h0003); exp_tx(16'hFFFE); exp_tx(16'hFFFF); exp_tx(16'h0000);
    send_pkt(16'h0102, 16'd3, 16'hFFFE);
    chk("inj_ready_drop", 32'(send_ready_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("inj_tx_cont", 32'(tx_o), 32'd1);
      tick();
    end
    chk("inj_tx_end", 32'(tx_o), 32'd0);
    chk("inj_ready_end", 32'(send_ready_o), 32'd1);
    chk("inj_tx_cnt", tx_pkt_cnt_o, 32'd1);

    // Receive a 2-payload packet with the consumer stalled
    recv_ready_i = 1'b0;
    exp_rx(1'b0, 16'h0100); exp_rx(1'b0, 16'h0002); exp_rx(1'b0, 16'h00AA); exp_rx(1'b1, 16'h00BB);
    rx_flit(16'h0100);
    chk("rx_latency_valid", 32'(recv_valid_o), 32'd1);
    chk("rx_head_data", 32'(recv_data_o), 32'h0100);
    chk("rx_head_last", 32'(recv_last_o), 32'd0);
    rx_flit(16'h0002);
    rx_flit(16'h00AA);
    rx_flit(16'h00BB);
    chk("rx_pkt_cnt1", rx_pkt_cnt_o, 32'd1);
    chk("rx_head_held", 32'(recv_data_o), 32'h0100);
    drain();

    // Fill all 16 entries, ignored 17th flit, single pop restores credit
    exp_rx(1'b0, 16'h0C00);
    exp_rx(1'b0, 16'd14);
    for (int i = 0; i < 14; i++) exp_rx(i == 13, 16'h1000 + 16'(i));
    rx_flit(16'h0C00);
    rx_flit(16'd14);
    for (int i = 0; i < 14; i++) rx_flit(16'h1000 + 16'(i));
    chk("full_credit", 32'(credit_o), 32'd0);
    chk("full_rx_cnt", rx_pkt_cnt_o, 32'd2);
    rx_i   = 1'b1;
    data_i = 16'hDEAD;
    tick();
    rx_i   = 1'b0;
    chk("full_ignore_credit", 32'(credit_o), 32'd0);
    chk("full_ignore_cnt", rx_pkt_cnt_o, 32'd2);
    recv_ready_i = 1'b1;
    chk("full_pop_same_cycle", 32'(credit_o), 32'd0);
    tick();
    recv_ready_i = 1'b0;
    chk("full_pop_next_cycle", 32'(credit_o), 32'd1);
    drain();

    // Zero-size packet out
    exp_tx(16'h0055); exp_tx(16'h0000);
    send_pkt(16'h0055, 16'd0, 16'h1234);
    chk("zs_tx_head", 32'(tx_o), 32'd1);
    tick();
    chk("zs_tx_size", 32'(tx_o), 32'd1);
    tick();
    chk("zs_tx_idle", 32'(tx_o), 32'd0);
    chk("zs_ready", 32'(send_ready_o), 32'd1);
    chk("zs_tx_cnt", tx_pkt_cnt_o, 32'd2);

    // Zero-size packet in, consumer running
    recv_ready_i = 1'b1;
    exp_rx(1'b0, 16'h0077); exp_rx(1'b1, 16'h0000);
    rx_flit(16'h0077);
    rx_flit(16'h0000);
    chk("zs_rx_cnt", rx_pkt_cnt_o, 32'd3);
    drain();

    // Credit withheld for 3 cycles mid-payload
    exp_tx(16'h0200); exp_tx(16'h0004); exp_tx(16'h0010);
    exp_tx(16'h0011); exp_tx(16'h0012); exp_tx(16'h0013);
    send_pkt(16'h0200, 16'd4, 16'h0010);
    repeat (3) tick();
    credit_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_tx", 32'(tx_o), 32'd1);
      chk("stall_data", 32'(data_o), 32'h0011);
      tick();
    end
    credit_i = 1'b1;
    wait_tx_idle();
    chk("stall_tx_cnt", tx_pkt_cnt_o, 32'd3);

    // Async reset with both directions mid-packet
    recv_ready_i = 1'b0;
    rx_flit(16'h0900);
    rx_flit(16'h0003);
    exp_tx(16'h0300); exp_tx(16'h0005); exp_tx(16'h0000);
    send_pkt(16'h0300, 16'd5, 16'h0000);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_tx", 32'(tx_o), 32'd0);
    chk("arst_data", 32'(data_o), 32'd0);
    chk("arst_ready", 32'(send_ready_o), 32'd0);
    chk("arst_credit", 32'(credit_o), 32'd0);
    chk("arst_recv_valid", 32'(recv_valid_o), 32'd0);
    chk("arst_tx_cnt", tx_pkt_cnt_o, 32'd0);
    chk("arst_rx_cnt", rx_pkt_cnt_o, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("arst_rel_credit", 32'(credit_o), 32'd1);
    chk("arst_tx_q_empty", 32'(tx_q.size()), 32'd0);

    exp_tx(16'h0400); exp_tx(16'h0001); exp_tx(16'h00AB);
    send_pkt(16'h0400, 16'd1, 16'h00AB);
    wait_tx_idle();
    chk("post_tx_cnt", tx_pkt_cnt_o, 32'd1);
    recv_ready_i = 1'b1;
    exp_rx(1'b0, 16'h0A00); exp_rx(1'b1, 16'h0000);
    rx_flit(16'h0A00);
    rx_flit(16'h0000);
    drain();
    chk("post_rx_cnt", rx_pkt_cnt_o, 32'd1);
    repeat (2) tick();
    chk("final_tx_q_empty", 32'(tx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
